noc_txn_scheduler: RTL and testbench

Arbitrates AXI NoC transfer requests from up to `NUM_REQ` local requesters and sequences the AXI master's `INIT_AXI_TXN` / `INIT_AXI_RXN` launch pulses, one transfer at a time. It drives the master's port-ID, message-length and address inputs from the granted request. It sits between the requester logic and the AXI master in the `design_1` block design, on the `M_AXI_ACLK` domain. Completion from the master is returned to the granted requester as a one-cycle tagged done pulse.

---
 rtl/noc_txn_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_noc_txn_scheduler.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_txn_scheduler.sv
// Round-robin scheduler that launches one AXI NoC transfer at a time and reports its completion.
// Define NOC_SCHED_TIMEOUT_EN to add a WAIT-state watchdog that completes a stuck transfer with an error.
module noc_txn_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int INIT_PULSE     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    M_AXI_ACLK,
   input  logic                    M_AXI_ARESET,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_is_rd,
   input  logic [8*NUM_REQ-1:0]    req_port_id,
   input  logic [32*NUM_REQ-1:0]   req_len,
   input  logic [32*NUM_REQ-1:0]   req_addr,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic                    INIT_AXI_TXN,
   output logic                    INIT_AXI_RXN,
   output logic [7:0]              PORT_ID_WR,
   output logic [7:0]              PORT_ID_RD,
   output logic [31:0]             MSG_LENGTH_WR,
   output logic [31:0]             MSG_LENGTH_RD,
   output logic [31:0]             INPUT_WADDR,
   output logic [31:0]             READ_ADDR,
   input  logic                    TXN_DONE,
   input  logic                    RXN_DONE,
   output logic                    done_valid,
   output logic [2:0]              done_id,
   output logic                    done_err,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMPLETE} state_t;

   state_t       state, state_next;
   logic [2:0]   rr_ptr, rr_next;
   logic [2:0]   winner;
   logic [3:0]   pcnt;
   logic         done_seen;
   logic         is_rd;
   logic         err_flag;
   logic         timeout_hit;

   logic [7:0]   valid_pad, rd_pad;
   logic [7:0]   port_arr [8];
   logic [31:0]  len_arr  [8];
   logic [31:0]  addr_arr [8];

   logic         any_req;
   logic         grant;
   logic [2:0]   win_idx;
   logic [3:0]   rr_sum;
   logic [2:0]   rr_idx;
   logic         win_zero;
   logic         match_done;
   logic [NUM_REQ-1:0] ack_next;

   // Unpack requester fields into fixed 8-entry tables so the winner can be selected by index.
   always_comb begin
      valid_pad = '0;
      rd_pad    = '0;
      valid_pad[NUM_REQ-1:0] = req_valid;
      rd_pad[NUM_REQ-1:0]    = req_is_rd;
      for (int i = 0; i < 8; i++) begin
         port_arr[i] = '0;
         len_arr[i]  = '0;
         addr_arr[i] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         port_arr[i] = req_port_id[8*i +: 8];
         len_arr[i]  = req_len[32*i +: 32];
         addr_arr[i] = req_addr[32*i +: 32];
      end
   end

   // Scan from the farthest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      any_req = 1'b0;
      win_idx = '0;
      rr_sum  = '0;
      rr_idx  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         rr_sum = {1'b0, rr_ptr} + 4'(k);
         if (rr_sum >= 4'(NUM_REQ)) rr_sum = rr_sum - 4'(NUM_REQ);
         rr_idx = rr_sum[2:0];
         if (valid_pad[rr_idx]) begin
            any_req = 1'b1;
            win_idx = rr_idx;
         end
      end
   end

   assign grant      = (state == IDLE) && any_req;
   assign win_zero   = (len_arr[win_idx] == 32'd0);
   assign match_done = is_rd ? RXN_DONE : TXN_DONE;
   assign rr_next    = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;

   always_comb begin
      ack_next = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack_next[i] = grant && (win_idx == 3'(i));
      end
   end

`ifdef NOC_SCHED_TIMEOUT_EN
   logic [15:0] tcnt;

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET || state != WAIT) tcnt <= '0;
      else                               tcnt <= tcnt + 16'd1;
   end

   assign timeout_hit = (state == WAIT) && (tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out; the parameter stays so both builds share one interface.
   assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (any_req) state_next = win_zero ? COMPLETE : LAUNCH;
         LAUNCH:   if (pcnt == 4'd0) state_next = (done_seen || match_done) ? COMPLETE : WAIT;
         WAIT:     if (match_done || timeout_hit) state_next = COMPLETE;
         COMPLETE: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs; the untouched direction keeps its last grant's values.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         winner        <= '0;
         pcnt          <= '0;
         done_seen     <= 1'b0;
         is_rd         <= 1'b0;
         err_flag      <= 1'b0;
         req_ack       <= '0;
         INIT_AXI_TXN  <= 1'b0;
         INIT_AXI_RXN  <= 1'b0;
         PORT_ID_WR    <= '0;
         PORT_ID_RD    <= '0;
         MSG_LENGTH_WR <= '0;
         MSG_LENGTH_RD <= '0;
         INPUT_WADDR   <= '0;
         READ_ADDR     <= '0;
         done_valid    <= 1'b0;
         done_id       <= '0;
         done_err      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != IDLE);
         req_ack    <= ack_next;
         done_valid <= 1'b0;
         done_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  winner    <= win_idx;
                  is_rd     <= rd_pad[win_idx];
                  rr_ptr    <= rr_next;
                  done_seen <= 1'b0;
                  err_flag  <= win_zero;
                  pcnt      <= 4'(INIT_PULSE - 1);
                  if (rd_pad[win_idx]) begin
                     PORT_ID_RD    <= port_arr[win_idx];
                     MSG_LENGTH_RD <= len_arr[win_idx];
                     READ_ADDR     <= addr_arr[win_idx];
                     INIT_AXI_RXN  <= !win_zero;
                  end else begin
                     PORT_ID_WR    <= port_arr[win_idx];
                     MSG_LENGTH_WR <= len_arr[win_idx];
                     INPUT_WADDR   <= addr_arr[win_idx];
                     INIT_AXI_TXN  <= !win_zero;
                  end
               end
            end
            LAUNCH: begin
               if (match_done) done_seen <= 1'b1;
               if (pcnt == 4'd0) begin
                  INIT_AXI_TXN <= 1'b0;
                  INIT_AXI_RXN <= 1'b0;
               end else begin
                  pcnt <= pcnt - 4'd1;
               end
            end
            WAIT: begin
               if (timeout_hit && !match_done) err_flag <= 1'b1;
            end
            COMPLETE: begin
               done_valid <= 1'b1;
               done_err   <= err_flag;
               done_id    <= winner;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_txn_scheduler.sv
// Scoreboard bench for noc_txn_scheduler: expected completions are queued at request time and
// retired on done_valid; define NOC_SCHED_TIMEOUT_EN to also exercise the watchdog.
module tb_noc_txn_scheduler;

   localparam int NUM_REQ    = 4;
   localparam int INIT_PULSE = 4;
`ifdef NOC_SCHED_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES = 16;
`else
   localparam int TIMEOUT_CYCLES = 4096;
`endif

   logic                  clk = 1'b0;
   logic                  M_AXI_ARESET;
   logic [NUM_REQ-1:0]    req_valid, req_is_rd, req_ack;
   logic [8*NUM_REQ-1:0]  req_port_id;
   logic [32*NUM_REQ-1:0] req_len, req_addr;
   logic                  INIT_AXI_TXN, INIT_AXI_RXN, TXN_DONE, RXN_DONE;
   logic [7:0]            PORT_ID_WR, PORT_ID_RD;
   logic [31:0]           MSG_LENGTH_WR, MSG_LENGTH_RD, INPUT_WADDR, READ_ADDR;
   logic                  done_valid, done_err, busy;
   logic [2:0]            done_id;

   typedef struct {
      logic [2:0] id;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   noc_txn_scheduler #(
      .NUM_REQ(NUM_REQ), .INIT_PULSE(INIT_PULSE), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
      .req_valid(req_valid), .req_is_rd(req_is_rd), .req_port_id(req_port_id),
      .req_len(req_len), .req_addr(req_addr), .req_ack(req_ack),
      .INIT_AXI_TXN(INIT_AXI_TXN), .INIT_AXI_RXN(INIT_AXI_RXN),
      .PORT_ID_WR(PORT_ID_WR), .PORT_ID_RD(PORT_ID_RD),
      .MSG_LENGTH_WR(MSG_LENGTH_WR), .MSG_LENGTH_RD(MSG_LENGTH_RD),
      .INPUT_WADDR(INPUT_WADDR), .READ_ADDR(READ_ADDR),
      .TXN_DONE(TXN_DONE), .RXN_DONE(RXN_DONE),
      .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int id, input logic rd, input logic [7:0] port,
                          input logic [31:0] len, input logic [31:0] addr);
      req_is_rd[id]          = rd;
      req_port_id[8*id +: 8] = port;
      req_len[32*id +: 32]   = len;
      req_addr[32*id +: 32]  = addr;
      req_valid[id]          = 1'b1;
   endtask

   task automatic wait_ack(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (req_ack != '0) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic wait_done(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (done_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic wait_init_low(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (!INIT_AXI_TXN && !INIT_AXI_RXN) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      M_AXI_ARESET = 1'b1;
      req_valid = '0; req_is_rd = '0; req_port_id = '0; req_len = '0; req_addr = '0;
      TXN_DONE = 1'b0; RXN_DONE = 1'b0;
      tick(); tick();
      checks++;
      if ({req_ack, INIT_AXI_TXN, INIT_AXI_RXN, done_valid, done_err, busy} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got %0h expected 0",
                  {req_ack, INIT_AXI_TXN, INIT_AXI_RXN, done_valid, done_err, busy});
      end
      checks++;
      if ({PORT_ID_WR, PORT_ID_RD, MSG_LENGTH_WR, MSG_LENGTH_RD, INPUT_WADDR, READ_ADDR, done_id} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_data: got %0h expected 0",
                  {PORT_ID_WR, PORT_ID_RD, MSG_LENGTH_WR, MSG_LENGTH_RD, INPUT_WADDR, READ_ADDR, done_id});
      end
      M_AXI_ARESET = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_single_write();
      int n; bit ok; int cnt; bit rxn_seen; exp_t e;
      set_req(1, 1'b0, 8'd2, 32'd5, 32'h40);
      exp_q.push_back('{3'd1, 1'b0});
      wait_ack(n, ok);
      checks++;
      if (!ok || n != 1) begin
         failures++;
         $display("[TB] FAIL wr_ack_latency: got %0d (seen=%0b) expected 1", n, ok);
      end
      checks++;
      if (req_ack !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL wr_ack: got %b expected 0010", req_ack);
      end
      checks++;
      if ({PORT_ID_WR, MSG_LENGTH_WR, INPUT_WADDR} !== {8'd2, 32'd5, 32'h40}) begin
         failures++;
         $display("[TB] FAIL wr_fields: got %0h/%0h/%0h expected 2/5/40", PORT_ID_WR, MSG_LENGTH_WR, INPUT_WADDR);
      end
      req_valid[1] = 1'b0;
      cnt = 0; rxn_seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (INIT_AXI_RXN) rxn_seen = 1'b1;
         if (!INIT_AXI_TXN) break;
         cnt++;
         tick();
      end
      checks++;
      if (cnt != INIT_PULSE || rxn_seen) begin
         failures++;
         $display("[TB] FAIL wr_init_pulse: got %0d cycles (rxn=%0b) expected %0d", cnt, rxn_seen, INIT_PULSE);
      end
      TXN_DONE = 1'b1;
      tick();
      TXN_DONE = 1'b0;
      wait_done(n, ok);
      checks++;
      if (!ok || n != 1) begin
         failures++;
         $display("[TB] FAIL wr_done_latency: got %0d (seen=%0b) expected 1", n, ok);
      end
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL wr_done: got id=%0d expected none", done_id);
      end else begin
         e = exp_q.pop_front();
         if (done_id !== e.id || done_err !== e.err) begin
            failures++;
            $display("[TB] FAIL wr_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
         end
      end
      tick();
      checks++;
      if (done_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wr_done_width: got valid=%b busy=%b expected 0/0", done_valid, busy);
      end
   endtask

   task automatic test_round_robin();
      int n; bit ok; int last; exp_t e; logic [3:0] exp_ack;
      M_AXI_ARESET = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 8'(10 + i), 32'(i + 1), 32'(256 * i));
      tick(); tick();
      M_AXI_ARESET = 1'b0;
      last = 0;
      for (int g = 0; g < 5; g++) begin
         wait_ack(n, ok);
         exp_ack = 4'b0001 << (g % 4);
         checks++;
         if (!ok || req_ack !== exp_ack) begin
            failures++;
            $display("[TB] FAIL rr_order: grant %0d got %b expected %b", g, req_ack, exp_ack);
         end
         checks++;
         if (PORT_ID_WR !== 8'(10 + g % 4)) begin
            failures++;
            $display("[TB] FAIL rr_port: grant %0d got %0d expected %0d", g, PORT_ID_WR, 10 + g % 4);
         end
         if (g > 0) begin
            checks++;
            if (cyc - last < INIT_PULSE + 3) begin
               failures++;
               $display("[TB] FAIL rr_spacing: got %0d expected >= %0d", cyc - last, INIT_PULSE + 3);
            end
         end
         last = cyc;
         exp_q.push_back('{3'(g % 4), 1'b0});
         if (g == 4) req_valid = '0;
         wait_init_low(ok);
         TXN_DONE = 1'b1;
         tick();
         TXN_DONE = 1'b0;
         wait_done(n, ok);
         checks++;
         if (!ok || exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL rr_done: got seen=%0b expected completion", ok);
         end else begin
            e = exp_q.pop_front();
            if (done_id !== e.id || done_err !== e.err) begin
               failures++;
               $display("[TB] FAIL rr_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
            end
         end
      end
      tick();
   endtask

   task automatic test_read_early_done();
      int n; bit ok; int cnt; bit stray_bad; exp_t e;
      set_req(2, 1'b1, 8'd8, 32'd5, 32'h2000);
      exp_q.push_back('{3'd2, 1'b0});
      wait_ack(n, ok);
      checks++;
      if (!ok || req_ack !== 4'b0100) begin
         failures++;
         $display("[TB] FAIL rd_ack: got %b expected 0100", req_ack);
      end
      checks++;
      if ({PORT_ID_RD, MSG_LENGTH_RD, READ_ADDR, PORT_ID_WR} !== {8'd8, 32'd5, 32'h2000, 8'd10}) begin
         failures++;
         $display("[TB] FAIL rd_fields: got %0h/%0h/%0h wr_port=%0h expected 8/5/2000 wr_port=a",
                  PORT_ID_RD, MSG_LENGTH_RD, READ_ADDR, PORT_ID_WR);
      end
      req_valid[2] = 1'b0;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (!INIT_AXI_RXN) break;
         cnt++;
         RXN_DONE = (c == 1);
         tick();
      end
      RXN_DONE = 1'b0;
      checks++;
      if (cnt != INIT_PULSE) begin
         failures++;
         $display("[TB] FAIL rd_init_pulse: got %0d expected %0d", cnt, INIT_PULSE);
      end
      wait_done(n, ok);
      checks++;
      if (!ok || n != 1 || exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL rd_early_done: got latency %0d (seen=%0b) expected 1", n, ok);
      end else begin
         e = exp_q.pop_front();
         if (done_id !== e.id || done_err !== e.err) begin
            failures++;
            $display("[TB] FAIL rd_early_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
         end
      end
      tick();
      set_req(0, 1'b1, 8'd9, 32'd3, 32'h3000);
      exp_q.push_back('{3'd0, 1'b0});
      wait_ack(n, ok);
      req_valid[0] = 1'b0;
      wait_init_low(ok);
      TXN_DONE = 1'b1;
      tick();
      TXN_DONE = 1'b0;
      stray_bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (done_valid || !busy) stray_bad = 1'b1;
         tick();
      end
      checks++;
      if (stray_bad) begin
         failures++;
         $display("[TB] FAIL rd_stray_txn_done: got completion/idle expected still waiting");
      end
      RXN_DONE = 1'b1;
      tick();
      RXN_DONE = 1'b0;
      wait_done(n, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL rd_done: got seen=%0b expected completion", ok);
      end else begin
         e = exp_q.pop_front();
         if (done_id !== e.id || done_err !== e.err) begin
            failures++;
            $display("[TB] FAIL rd_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
         end
      end
      tick();
   endtask

   task automatic test_zero_length();
      int n; bit ok; exp_t e;
      set_req(3, 1'b0, 8'h33, 32'd0, 32'h500);
      exp_q.push_back('{3'd3, 1'b1});
      wait_ack(n, ok);
      checks++;
      if (!ok || req_ack !== 4'b1000 || INIT_AXI_TXN || INIT_AXI_RXN || done_valid) begin
         failures++;
         $display("[TB] FAIL zero_grant: got ack=%b init=%b%b dv=%b expected 1000/00/0",
                  req_ack, INIT_AXI_TXN, INIT_AXI_RXN, done_valid);
      end
      req_valid[3] = 1'b0;
      tick();
      checks++;
      if (done_valid !== 1'b1 || INIT_AXI_TXN || exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL zero_done: got dv=%b init=%b expected 1/0", done_valid, INIT_AXI_TXN);
      end else begin
         e = exp_q.pop_front();
         if (done_id !== e.id || done_err !== e.err) begin
            failures++;
            $display("[TB] FAIL zero_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid_launch();
      int n; bit ok; bit late_done; exp_t e;
      set_req(1, 1'b0, 8'd5, 32'd7, 32'h600);
      wait_ack(n, ok);
      req_valid[1] = 1'b0;
      tick();
      checks++;
      if (INIT_AXI_TXN !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rst_pre_init: got %b expected 1", INIT_AXI_TXN);
      end
      M_AXI_ARESET = 1'b1;
      tick();
      checks++;
      if ({req_ack, INIT_AXI_TXN, INIT_AXI_RXN, PORT_ID_WR, PORT_ID_RD, MSG_LENGTH_WR, MSG_LENGTH_RD,
           INPUT_WADDR, READ_ADDR, done_valid, done_id, done_err, busy} !== '0) begin
         failures++;
         $display("[TB] FAIL rst_mid_launch: got %0h expected 0",
                  {req_ack, INIT_AXI_TXN, INIT_AXI_RXN, PORT_ID_WR, PORT_ID_RD, MSG_LENGTH_WR, MSG_LENGTH_RD,
                   INPUT_WADDR, READ_ADDR, done_valid, done_id, done_err, busy});
      end
      M_AXI_ARESET = 1'b0;
      late_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (done_valid) late_done = 1'b1;
      end
      checks++;
      if (late_done) begin
         failures++;
         $display("[TB] FAIL rst_no_done: got done_valid expected none");
      end
      set_req(1, 1'b0, 8'd6, 32'd2, 32'h700);
      set_req(3, 1'b0, 8'd7, 32'd2, 32'h800);
      exp_q.push_back('{3'd1, 1'b0});
      wait_ack(n, ok);
      checks++;
      if (!ok || req_ack !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL rst_rr_ptr: got %b expected 0010", req_ack);
      end
      req_valid = '0;
      wait_init_low(ok);
      TXN_DONE = 1'b1;
      tick();
      TXN_DONE = 1'b0;
      wait_done(n, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL rst_after_done: got seen=%0b expected completion", ok);
      end else begin
         e = exp_q.pop_front();
         if (done_id !== e.id || done_err !== e.err) begin
            failures++;
            $display("[TB] FAIL rst_after_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
         end
      end
      tick();
   endtask

`ifdef NOC_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int n; bit ok; bit late; exp_t e;
      set_req(2, 1'b0, 8'd1, 32'd4, 32'h900);
      exp_q.push_back('{3'd2, 1'b1});
      wait_ack(n, ok);
      req_valid[2] = 1'b0;
      wait_init_low(ok);
      wait_done(n, ok);
      checks++;
      if (!ok || n < TIMEOUT_CYCLES || n > TIMEOUT_CYCLES + 2 || exp_q.size() == 0) begin
         failures++;
         $display("[TB] FAIL timeout_latency: got %0d (seen=%0b) expected %0d..%0d", n, ok, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 2);
      end else begin
         e = exp_q.pop_front();
         if (done_id !== e.id || done_err !== e.err) begin
            failures++;
            $display("[TB] FAIL timeout_done: got id=%0d err=%b expected id=%0d err=%b", done_id, done_err, e.id, e.err);
         end
      end
      tick();
      TXN_DONE = 1'b1;
      tick();
      TXN_DONE = 1'b0;
      late = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (done_valid || busy) late = 1'b1;
         tick();
      end
      checks++;
      if (late) begin
         failures++;
         $display("[TB] FAIL timeout_late_done: got activity expected idle");
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_read_early_done();
      test_zero_length();
      test_reset_mid_launch();
`ifdef NOC_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

endmodule
